// File: rtl/hex_resp_tx.sv
// Formats a binary value as an ASCII hex line ("0x" prefix, MSB-first digits, CR/LF) and
// feeds it byte by byte into the uart_if tx_irq/tx_data/tx_busy handshake.
module hex_resp_tx #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PREFIX_EN  = 1,
    parameter int unsigned EOL_CRLF   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  tx_irq_o,
    output logic [7:0]            tx_data_o,
    input  logic                  tx_busy_i
);

    localparam int unsigned NumDigits = DATA_WIDTH / 4;
    localparam int unsigned PfxLen    = (PREFIX_EN != 0) ? 2 : 0;
    localparam int unsigned EolLen    = (EOL_CRLF != 0) ? 2 : 1;
    localparam int unsigned LineLen   = PfxLen + NumDigits + EolLen;
    localparam int unsigned IdxW      = $clog2(LineLen + 1);

    localparam logic [IdxW-1:0] LastIdx = IdxW'(LineLen - 1);
    localparam logic [IdxW-1:0] EolLo   = IdxW'(PfxLen + NumDigits);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StHold,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  busy_q, done_q, tx_irq_q;
    logic [7:0]            tx_data_q;
    logic                  fire_d;
    logic [7:0]            byte_d;

    function automatic logic in_prefix(input logic [IdxW-1:0] idx);
        return (PREFIX_EN != 0) && (idx < IdxW'(2));
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    function automatic logic [7:0] line_byte(input logic [IdxW-1:0] idx, input logic [3:0] nib);
        if (in_prefix(idx)) begin
            return (idx == '0) ? 8'h30 : 8'h78;
        end
        if (idx < EolLo) begin
            return hex_ascii(nib);
        end
        if ((EOL_CRLF != 0) && (idx == EolLo)) begin
            return 8'h0D;
        end
        return 8'h0A;
    endfunction

    // A pulse is visible for the whole SEND cycle in which it is issued, so tx_irq_q
    // means "the byte at idx_q goes out now".
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (req_i) begin
                    state_d = StSend;
                    idx_d   = '0;
                    shift_d = req_data_i;
                end else begin
                    state_d = StIdle;
                end
            end
            StSend: begin
                if (tx_irq_q) begin
                    idx_d = idx_q + 1'b1;
                    if (!in_prefix(idx_q) && (idx_q < EolLo)) begin
                        shift_d = shift_q << 4;
                    end
                    state_d = (idx_q == LastIdx) ? StDone : StHold;
                end
            end
            StHold: begin
                state_d = StSend;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from next-state values; the pulse decision for the coming
    // SEND cycle uses tx_busy_i sampled in the cycle before it.
    always_comb begin
        fire_d = (state_d == StSend) && !tx_busy_i;
        byte_d = line_byte(idx_d, shift_d[DATA_WIDTH-1 -: 4]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            shift_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tx_irq_q  <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            busy_q   <= (state_d == StSend) || (state_d == StHold);
            done_q   <= (state_d == StDone);
            tx_irq_q <= fire_d;
            if (fire_d) begin
                tx_data_q <= byte_d;
            end
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign tx_irq_o  = tx_irq_q;
    assign tx_data_o = tx_data_q;

endmodule

// File: tb/tb_hex_resp_tx.sv
// Scoreboard bench for hex_resp_tx: default 32-bit instance plus an 8-bit, no-prefix, LF-only one.
module tb_hex_resp_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] req_data;
    logic        tx_busy;
    logic        busy, done, irq;
    logic [7:0]  data;

    logic        s_req;
    logic [7:0]  s_req_data;
    logic        s_tx_busy;
    logic        s_busy, s_done, s_irq;
    logic [7:0]  s_data;

    always #5 clk = ~clk;

    hex_resp_tx dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .req_data_i (req_data),
        .busy_o     (busy),
        .done_o     (done),
        .tx_irq_o   (irq),
        .tx_data_o  (data),
        .tx_busy_i  (tx_busy)
    );

    hex_resp_tx #(
        .DATA_WIDTH (8),
        .PREFIX_EN  (0),
        .EOL_CRLF   (0)
    ) dut_s (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (s_req),
        .req_data_i (s_req_data),
        .busy_o     (s_busy),
        .done_o     (s_done),
        .tx_irq_o   (s_irq),
        .tx_data_o  (s_data),
        .tx_busy_i  (s_tx_busy)
    );

    typedef struct packed {
        logic [7:0]  b;
        int unsigned gap;  // required distance from previous pulse, 0 = any (>= 2)
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] s_exp_q[$];
    int checks = 0, errors = 0;
    int cyc = 0, last_pulse = -100, pulse_cnt = 0;
    int done_cnt = 0, exp_done = 0, s_done_cnt = 0, s_exp_done = 0;
    logic       prev_irq = 1'b0, s_prev_irq = 1'b0;
    logic [7:0] prev_byte = 8'h00, s_prev_byte = 8'h00;
    logic       busy_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Main monitor
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_irq = 1'b0;
        end else begin
            if (irq) begin
                exp_t e;
                pulse_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected pulse: got %0h expected none", data);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx byte", {24'h0, data}, {24'h0, e.b});
                    if (e.gap != 0) chk("pulse gap", cyc - last_pulse, e.gap);
                end
                chk("min pulse spacing", {31'h0, (cyc - last_pulse) >= 2}, 1);
                chk("busy during pulse", {31'h0, busy}, 1);
                chk("tx_busy low at pulse", {31'h0, tx_busy}, 0);
                last_pulse = cyc;
            end
            if (done) begin
                done_cnt++;
                chk("done after last 0A pulse", {23'h0, prev_irq, prev_byte}, {23'h0, 1'b1, 8'h0A});
                chk("busy low in done", {31'h0, busy}, 0);
            end
            prev_irq  = irq;
            prev_byte = data;
        end
    end

    // Small-instance monitor
    initial forever begin
        @(negedge clk);
        if (rst) begin
            s_prev_irq = 1'b0;
        end else begin
            if (s_irq) begin
                if (s_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL small unexpected pulse: got %0h expected none", s_data);
                end else begin
                    chk("small tx byte", {24'h0, s_data}, {24'h0, s_exp_q.pop_front()});
                end
            end
            if (s_done) begin
                s_done_cnt++;
                chk("small done after 0A", {23'h0, s_prev_irq, s_prev_byte}, {23'h0, 1'b1, 8'h0A});
            end
            s_prev_irq  = s_irq;
            s_prev_byte = s_data;
        end
    end

    // uart_if stand-in: busy for 20 cycles after each pulse
    initial forever begin
        @(negedge clk);
        if (irq && busy_mode) begin
            @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat (20) @(posedge clk);
            #1 tx_busy = 1'b0;
        end
    end

    task automatic push_line(input logic [95:0] line, input int unsigned first_gap,
                             input int unsigned rest_gap);
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            e.b   = line[95-8*i -: 8];
            e.gap = (i == 0) ? first_gap : rest_gap;
            exp_q.push_back(e);
        end
        exp_done++;
    endtask

    task automatic send_req(input logic [31:0] d);
        @(negedge clk);
        #1 req = 1'b1;
        req_data = d;
        @(negedge clk);
        #1 req = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || done_cnt != exp_done || busy) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({name, " bytes outstanding"}, exp_q.size(), 0);
        chk({name, " done count"}, done_cnt, exp_done);
        exp_q.delete();
    endtask

    task automatic wait_pulses(input int target, input int budget);
        int n = 0;
        while (pulse_cnt < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("pulse count reached", pulse_cnt, target);
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        req        = 1'b0;
        req_data   = '0;
        tx_busy    = 1'b0;
        s_req      = 1'b0;
        s_req_data = '0;
        s_tx_busy  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", {31'h0, busy}, 0);
        chk("reset done", {31'h0, done}, 0);
        chk("reset irq", {31'h0, irq}, 0);
        chk("reset data", {24'h0, data}, 0);
        chk("reset small busy", {31'h0, s_busy}, 0);
        chk("reset small data", {24'h0, s_data}, 0);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: defaults, tx_busy low, pulses every second cycle
        push_line(96'h30_78_31_32_33_34_41_42_43_44_0D_0A, 0, 2);
        send_req(32'h1234ABCD);
        wait_idle("line 1234ABCD", 100);

        // 2: same line against a slow transmitter
        busy_mode = 1'b1;
        push_line(96'h30_78_31_32_33_34_41_42_43_44_0D_0A, 0, 0);
        send_req(32'h1234ABCD);
        wait_idle("slow line 1234ABCD", 600);
        busy_mode = 1'b0;
        repeat (25) @(negedge clk);

        // 3: 8-bit instance, no prefix, LF only
        s_exp_q.push_back(8'h30);
        s_exp_q.push_back(8'h46);
        s_exp_q.push_back(8'h0A);
        s_exp_done++;
        @(negedge clk);
        #1 s_req = 1'b1;
        s_req_data = 8'h0F;
        @(negedge clk);
        #1 s_req = 1'b0;
        n = 0;
        while ((s_done_cnt != s_exp_done || s_exp_q.size() != 0) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("small bytes outstanding", s_exp_q.size(), 0);
        chk("small done count", s_done_cnt, s_exp_done);

        // 4: request while busy is ignored; request in the DONE cycle chains
        push_line(96'h30_78_30_30_30_30_30_30_30_30_0D_0A, 0, 2);
        n = pulse_cnt;
        send_req(32'h0000_0000);
        wait_pulses(n + 5, 40);
        req = 1'b1;
        req_data = 32'hFFFF_FFFF;
        @(negedge clk);
        #1 req = 1'b0;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done seen for zero line", {31'h0, done}, 1);
        req = 1'b1;
        req_data = 32'hFFFF_FFFF;
        push_line(96'h30_78_46_46_46_46_46_46_46_46_0D_0A, 2, 2);
        @(negedge clk);
        #1 req = 1'b0;
        wait_idle("back-to-back lines", 100);

        // 5: reset mid-line abandons it; next line is complete
        push_line(96'h30_78_44_45_00_00_00_00_00_00_00_00, 0, 2);
        exp_done--;
        repeat (8) void'(exp_q.pop_back());
        n = pulse_cnt;
        send_req(32'hDEAD_BEEF);
        wait_pulses(n + 4, 40);
        rst = 1'b1;
        #1;
        chk("async reset irq", {31'h0, irq}, 0);
        chk("async reset busy", {31'h0, busy}, 0);
        chk("async reset done", {31'h0, done}, 0);
        chk("async reset data", {24'h0, data}, 0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle after reset", {31'h0, busy}, 0);
        push_line(96'h30_78_30_30_30_30_30_30_30_31_0D_0A, 0, 2);
        send_req(32'h0000_0001);
        wait_idle("line after reset", 100);

        repeat (5) @(negedge clk);
        chk("final done count", done_cnt, exp_done);
        chk("final small done count", s_done_cnt, s_exp_done);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_resp_tx.md
# hex_resp_tx

Response encoder on the transmit side of the UART command path: the counterpart of the command parser. It takes a binary value (e.g. a register read result), converts it to an ASCII hexadecimal line, and sends that line one byte at a time into the UART interface's tx port. It uses the `tx_irq`/`tx_data`/`tx_busy` handshake. It sits between the command-execution logic and `uart_if`, in place of the direct echo path.

## Interface
- `DATA_WIDTH`, 32: width of the value to print; must be a multiple of 4 and at least 4.
- `PREFIX_EN`, 1: 1 emits the ASCII prefix "0x" before the digits; 0 emits no prefix.
- `EOL_CRLF`, 1: 1 terminates the line with CR LF (0x0D 0x0A); 0 terminates with LF (0x0A) only.
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_i`  in  1  1-clk pulse requesting one line; accepted only while `busy_o`=0.
- `req_data_i`  in  DATA_WIDTH  value to print; sampled in the acceptance cycle.
- `busy_o`  out  1  1 from the cycle after acceptance until the line completes.
- `done_o`  out  1  1-clk pulse when the last byte of the line has been issued.
- `tx_irq_o`  out  1  1-clk pulse that issues `tx_data_o` to `uart_if`.
- `tx_data_o`  out  8  byte to send; valid in the `tx_irq_o` cycle, holds its last value otherwise.
- `tx_busy_i`  in  1  from `uart_if`; 1 means the transmitter cannot take a byte.

## Operation
- Line length N = 2·PREFIX_EN + DATA_WIDTH/4 + (1+EOL_CRLF).
- The byte index counter has width ceil(log2(N+1)).
- Byte order:
  - prefix '0' (0x30), 'x' (0x78);
  - then the nibbles, most significant first;
  - then the EOL bytes.
- Digit encoding: nibble 0–9 → 0x30–0x39; nibble A–F → 0x41–0x46 (uppercase only).
- Data is latched on acceptance in a DATA_WIDTH shift register. The register shifts left by 4 after each digit is issued; the top nibble is always the next digit.
- FSM states:
  - IDLE: `busy_o`=0. On `req_i`: latch data, clear the index, go to SEND.
  - SEND: when `tx_busy_i`=0, pulse `tx_irq_o` with the current byte and increment the index. If that byte was the last, go to DONE; else go to HOLD. While `tx_busy_i`=1, stay in SEND with no pulse.
  - HOLD: exactly one cycle, no pulse, `tx_busy_i` ignored. This gives `uart_if` a cycle to raise busy. Then go to SEND.
  - DONE: `done_o`=1 and `busy_o`=0 for one cycle; `req_i` is accepted here exactly as in IDLE. Then go to IDLE, or to SEND if a request was accepted.
- `req_i` while `busy_o`=1 (SEND/HOLD) is ignored; the latched data is unchanged.
- `rst_i` asserted mid-line:
  - the line is abandoned immediately;
  - no `done_o` pulse;
  - no further `tx_irq_o`;
  - after release, the FSM is in IDLE.
- `tx_busy_i` dropping in the same cycle as a pulse has no effect; the next byte still waits for HOLD.

## Timing
- Reset values: state IDLE, `busy_o`=0, `done_o`=0, `tx_irq_o`=0, `tx_data_o`=0x00, index 0, shift register 0.
- Request accepted in cycle 0 → first `tx_irq_o` at cycle 1 at the earliest (if `tx_busy_i`=0).
- Consecutive `tx_irq_o` pulses are at least 2 cycles apart (SEND, HOLD).
- With `tx_busy_i` held 0, the line takes 2N−1 cycles from the first to the last pulse.
- `done_o` occurs in the cycle after the last `tx_irq_o`.
- `busy_o` is 1 from cycle 1 through the last-pulse cycle.
- All outputs are registered; no combinational path from `tx_busy_i` or `req_i` to any output.
- Back-to-back requests accepted in the DONE cycle start their first byte one cycle later. That cycle is two cycles after the previous last pulse, so the HOLD rule is preserved.

## Test plan
- Defaults, `req_data_i`=0x1234ABCD, `tx_busy_i`=0 → 12 pulses, bytes 30 78 31 32 33 34 41 42 43 44 0D 0A, pulses every 2nd cycle, one `done_o` the cycle after byte 0x0A.
- Same request, `tx_busy_i` high for 20 cycles after each pulse (emulating `uart_if` at 115200) → same 12 bytes in order, no pulse while `tx_busy_i`=1, no lost or duplicated byte.
- `DATA_WIDTH`=8, `PREFIX_EN`=0, `EOL_CRLF`=0, value 0x0F → bytes 30 46 0A, then `done_o`.
- Request 0x00000000, second `req_i` of 0xFFFFFFFF during byte 5 → line "0x00000000\r\n" only, one `done_o`. A request 0xFFFFFFFF in the DONE cycle → "0xFFFFFFFF\r\n" follows with the first pulse 2 cycles after the previous last.
- Assert `rst_i` after the 4th pulse of 0xDEADBEEF → outputs go to reset values asynchronously, no `done_o`. A new request 0x00000001 after release → full line 30 78 30 30 30 30 30 30 30 31 0D 0A.
